dds_drg_responder: RTL and testbench
====================================

Name: dds_drg_responder

Overview:
- Synthesizable stand-in for the AD9910 digital ramp generator (DRG), the far end of the io_update / drctl / drhold / drover interface.
- It accepts io_update, drctl and drhold, runs a saturating ramp accumulator, and produces drover plus the ramp value.
- It lets the trigger/OSK control logic be looped back on-FPGA and in simulation without a DDS chip fitted.

Parameters:
- WIDTH, 16, ramp accumulator and limit/step width.
- RATE_W, 16, ramp-rate divider width.

Ports:
- sys_clk  in  1  system clock, 500 MHz.
- sys_rst  in  1  reset; synchronous, active-high.
- io_update  in  1  async; rising edge loads the shadow config and restarts the ramp.
- drctl  in  1  async; ramp direction: 1 = up, 0 = down.
- drhold  in  1  async; 1 freezes the ramp.
- cfg_lower  in  WIDTH  shadow lower limit.
- cfg_upper  in  WIDTH  shadow upper limit.
- cfg_step_up  in  WIDTH  increment per up-step.
- cfg_step_down  in  WIDTH  decrement per down-step.
- cfg_rate_up  in  RATE_W  up-step interval = cfg_rate_up+1 clocks.
- cfg_rate_down  in  RATE_W  down-step interval = cfg_rate_down+1 clocks.
- drover  out  1  registered; high while the ramp sits at a limit.
- ramp_out  out  WIDTH  registered accumulator value.
- ramp_active  out  1  high after the first io_update.

Behaviour:
- Reset:
  - state=INIT; drover=0, ramp_out=0, ramp_active=0.
  - Rate counter 0; sync flops 0; active config 0.
- Input synchronisation:
  - io_update, drctl and drhold each pass through a 2-flop register; s2 is the stage used.
  - io_update rise is s2 high while the previous s2 sample was low.
  - An input change at sampling edge k is acted on by the FSM at edge k+2; drover changes at edge k+2.
- Load on io_update rise (any state, including mid-ramp):
  - Copy all cfg_* into the active registers.
  - If cfg_lower > cfg_upper, the active upper becomes cfg_lower.
  - acc <= lower, rate_cnt <= 0, ramp_active <= 1.
  - state <= BOTTOM, or TOP if drctl_s=1 and lower==upper.
  - Load has priority over drhold and over every other transition in that cycle.
- States: INIT, UP, DOWN, TOP, BOTTOM. Shared encoding is defined in the package.
- INIT: ignores drctl and drhold; leaves only on load.
- BOTTOM:
  - drctl_s=1 -> UP with rate_cnt=0.
  - If acc==upper, go straight to TOP instead.
- TOP:
  - drctl_s=0 -> DOWN with rate_cnt=0.
  - If acc==lower, stay in BOTTOM-equivalent: go to BOTTOM.
- UP:
  - drctl_s=0 -> DOWN, rate_cnt=0.
  - Else if rate_cnt==rate_up: compute sum=acc+step_up in WIDTH+1 bits.
    - sum >= upper -> acc=upper, state=TOP.
    - Otherwise acc=sum.
    - rate_cnt=0.
  - Else rate_cnt++.
- DOWN:
  - Mirror of UP.
  - Compute diff in WIDTH+1 bits, signed.
  - diff <= lower -> acc=lower, state=BOTTOM.
- drover = (state==TOP) || (state==BOTTOM), registered with the state.
- drhold_s=1 (not INIT, no load that cycle): acc, rate_cnt and state all freeze; drover is held.
- step=0: the ramp never moves and drover stays 0 in UP/DOWN. This is legal.
- Accumulator never wraps; saturation is exact at both limits.
- drctl toggling faster than a step interval: each toggle restarts rate_cnt; no step is lost or doubled.
- Synchronous reset mid-ramp: returns to INIT with all reset values on the next edge.

Decomposition:
- Package dds_drg_pkg holds:
  - state localparams (INIT/UP/DOWN/TOP/BOTTOM, 3-bit);
  - default WIDTH/RATE_W;
  - sync depth constant (2).
- One sub-module, dds_drg_accum:
  - saturating add/sub of acc with step against a limit;
  - outputs next_acc and hit_limit;
  - purely combinational.
- The FSM, rate counter and synchronisers stay in the top module.

Test Plan:
1. Reset, then drive io_update, drctl and drhold with no io_update rise -> drover=0, ramp_out=0, ramp_active=0 throughout.
2. Load lower=100, upper=200, step_up=10, rate_up=4, then drctl 0->1:
   - drover falls at edge k+2;
   - ramp_out steps by 10 every 5 clocks;
   - drover returns high exactly 50 clocks later with ramp_out=200.
3. From TOP, drctl 1->0 with step_down=30, rate_down=0:
   - ramp_out goes 170, 140, 110, then saturates at 100;
   - drover goes high on the 4th step.
4. drhold=1 for 20 clocks mid-UP at ramp_out=150 -> ramp_out stays at 150 and the rate phase resumes unchanged after release; total up-time grows by exactly 20 clocks.
5. io_update rise mid-DOWN with new lower=0, upper=0xFFFF, step_up=0xFFF0:
   - ramp_out reloads to 0;
   - first up-step gives 0xFFF0, second saturates at 0xFFFF; no wrap.
6. Load cfg_lower=300, cfg_upper=200 -> acc pinned at 300 and drover=1 for both drctl values; sys_rst mid-ramp -> INIT with all outputs 0.

Source files
------------

// File: rtl/dds_drg_pkg.sv
// Shared definitions for the DRG responder: the ramp FSM state encoding, default widths
// and the depth of the input synchroniser chains.
package dds_drg_pkg;

    localparam int unsigned DefWidth  = 16;
    localparam int unsigned DefRateW  = 16;
    localparam int unsigned SyncDepth = 2;

    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StUp     = 3'd1,
        StDown   = 3'd2,
        StTop    = 3'd3,
        StBottom = 3'd4
    } drg_state_e;

endpackage

// File: rtl/dds_drg_accum.sv
// Saturating ramp step: adds (dir_up=1) or subtracts (dir_up=0) step from acc and clamps
// the result at limit. Purely combinational.
//   acc       current accumulator value
//   step      step magnitude
//   limit     upper limit when ramping up, lower limit when ramping down
//   dir_up    1 = add, 0 = subtract
//   next_acc  clamped result
//   hit_limit result landed on (or crossed) the limit
module dds_drg_accum
    import dds_drg_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir_up,
    output logic [WIDTH-1:0] next_acc,
    output logic             hit_limit
);

    // One extra bit so neither the sum nor the difference can wrap before the compare.
    logic [WIDTH:0]        sum;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] limit_s;

    always_comb begin
        sum       = {1'b0, acc} + {1'b0, step};
        diff      = $signed({1'b0, acc}) - $signed({1'b0, step});
        limit_s   = $signed({1'b0, limit});
        next_acc  = acc;
        hit_limit = 1'b0;
        if (dir_up) begin
            if (sum >= {1'b0, limit}) begin
                next_acc  = limit;
                hit_limit = 1'b1;
            end else begin
                next_acc = sum[WIDTH-1:0];
            end
        end else begin
            if (diff <= limit_s) begin
                next_acc  = limit;
                hit_limit = 1'b1;
            end else begin
                next_acc = diff[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/dds_drg_responder.sv
// Stand-in for the AD9910 digital ramp generator. Synchronises io_update/drctl/drhold,
// loads the shadow config on an io_update rise and runs a saturating ramp between the
// active lower and upper limits.
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   io_update, drctl, drhold  asynchronous control inputs (2-flop synchronised)
//   cfg_*                     shadow config, captured on io_update rise
//   drover                    high while the ramp rests at a limit
//   ramp_out                  accumulator value
//   ramp_active               high once the first config load has happened
module dds_drg_responder
    import dds_drg_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned RATE_W = DefRateW
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              io_update,
    input  logic              drctl,
    input  logic              drhold,
    input  logic [WIDTH-1:0]  cfg_lower,
    input  logic [WIDTH-1:0]  cfg_upper,
    input  logic [WIDTH-1:0]  cfg_step_up,
    input  logic [WIDTH-1:0]  cfg_step_down,
    input  logic [RATE_W-1:0] cfg_rate_up,
    input  logic [RATE_W-1:0] cfg_rate_down,
    output logic              drover,
    output logic [WIDTH-1:0]  ramp_out,
    output logic              ramp_active
);

    logic [SyncDepth-1:0] io_sync_q, io_sync_d;
    logic [SyncDepth-1:0] dc_sync_q, dc_sync_d;
    logic [SyncDepth-1:0] dh_sync_q, dh_sync_d;
    logic                 io_prev_q, io_prev_d;

    drg_state_e        state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
    logic [WIDTH-1:0]  lower_q, lower_d, upper_q, upper_d;
    logic [WIDTH-1:0]  step_up_q, step_up_d, step_down_q, step_down_d;
    logic [RATE_W-1:0] rate_up_q, rate_up_d, rate_down_q, rate_down_d;
    logic              active_q, active_d;
    logic              drover_q, drover_d;

    logic             io_s, drctl_s, drhold_s, io_rise;
    logic [WIDTH-1:0] upper_eff;
    logic             dir_up;
    logic [WIDTH-1:0] step_sel, limit_sel, next_acc;
    logic             hit_limit;

    always_comb begin
        io_sync_d = {io_sync_q[SyncDepth-2:0], io_update};
        dc_sync_d = {dc_sync_q[SyncDepth-2:0], drctl};
        dh_sync_d = {dh_sync_q[SyncDepth-2:0], drhold};
        io_s      = io_sync_q[SyncDepth-1];
        drctl_s   = dc_sync_q[SyncDepth-1];
        drhold_s  = dh_sync_q[SyncDepth-1];
        io_prev_d = io_s;
        io_rise   = io_s & ~io_prev_q;
    end

    assign dir_up    = (state_q == StUp);
    assign step_sel  = dir_up ? step_up_q : step_down_q;
    assign limit_sel = dir_up ? upper_q : lower_q;

    dds_drg_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .acc       (acc_q),
        .step      (step_sel),
        .limit     (limit_sel),
        .dir_up    (dir_up),
        .next_acc  (next_acc),
        .hit_limit (hit_limit)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rate_cnt_d  = rate_cnt_q;
        lower_d     = lower_q;
        upper_d     = upper_q;
        step_up_d   = step_up_q;
        step_down_d = step_down_q;
        rate_up_d   = rate_up_q;
        rate_down_d = rate_down_q;
        active_d    = active_q;
        // An inverted window collapses onto the lower limit.
        upper_eff   = (cfg_lower > cfg_upper) ? cfg_lower : cfg_upper;

        if (io_rise) begin
            // Load wins over hold and over any ramp transition in the same cycle.
            lower_d     = cfg_lower;
            upper_d     = upper_eff;
            step_up_d   = cfg_step_up;
            step_down_d = cfg_step_down;
            rate_up_d   = cfg_rate_up;
            rate_down_d = cfg_rate_down;
            acc_d       = cfg_lower;
            rate_cnt_d  = '0;
            active_d    = 1'b1;
            state_d     = (drctl_s && (cfg_lower == upper_eff)) ? StTop : StBottom;
        end else if (state_q != StInit && !drhold_s) begin
            unique case (state_q)
                StBottom: begin
                    if (drctl_s) begin
                        rate_cnt_d = '0;
                        state_d    = (acc_q == upper_q) ? StTop : StUp;
                    end
                end
                StTop: begin
                    if (!drctl_s) begin
                        rate_cnt_d = '0;
                        state_d    = (acc_q == lower_q) ? StBottom : StDown;
                    end
                end
                StUp: begin
                    if (!drctl_s) begin
                        state_d    = StDown;
                        rate_cnt_d = '0;
                    end else if (rate_cnt_q == rate_up_q) begin
                        acc_d      = next_acc;
                        rate_cnt_d = '0;
                        if (hit_limit) state_d = StTop;
                    end else begin
                        rate_cnt_d = rate_cnt_q + RATE_W'(1);
                    end
                end
                StDown: begin
                    if (drctl_s) begin
                        state_d    = StUp;
                        rate_cnt_d = '0;
                    end else if (rate_cnt_q == rate_down_q) begin
                        acc_d      = next_acc;
                        rate_cnt_d = '0;
                        if (hit_limit) state_d = StBottom;
                    end else begin
                        rate_cnt_d = rate_cnt_q + RATE_W'(1);
                    end
                end
                default: ;
            endcase
        end

        drover_d = (state_d == StTop) || (state_d == StBottom);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            io_sync_q   <= '0;
            dc_sync_q   <= '0;
            dh_sync_q   <= '0;
            io_prev_q   <= 1'b0;
            state_q     <= StInit;
            acc_q       <= '0;
            rate_cnt_q  <= '0;
            lower_q     <= '0;
            upper_q     <= '0;
            step_up_q   <= '0;
            step_down_q <= '0;
            rate_up_q   <= '0;
            rate_down_q <= '0;
            active_q    <= 1'b0;
            drover_q    <= 1'b0;
        end else begin
            io_sync_q   <= io_sync_d;
            dc_sync_q   <= dc_sync_d;
            dh_sync_q   <= dh_sync_d;
            io_prev_q   <= io_prev_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            rate_cnt_q  <= rate_cnt_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            rate_up_q   <= rate_up_d;
            rate_down_q <= rate_down_d;
            active_q    <= active_d;
            drover_q    <= drover_d;
        end
    end

    assign drover      = drover_q;
    assign ramp_out    = acc_q;
    assign ramp_active = active_q;

endmodule

// File: tb/tb_dds_drg_responder.sv
// Bench for dds_drg_responder: directed ramp scenarios followed by randomized control
// and config traffic, all checked every cycle against a behavioural ramp model.
module tb_dds_drg_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        io_update, drctl, drhold;
    logic [15:0] cfg_lower, cfg_upper, cfg_step_up, cfg_step_down;
    logic [15:0] cfg_rate_up, cfg_rate_down;
    logic        drover;
    logic [15:0] ramp_out;
    logic        ramp_active;

    always #1 sys_clk = ~sys_clk;

    dds_drg_responder #(
        .WIDTH  (16),
        .RATE_W (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .io_update     (io_update),
        .drctl         (drctl),
        .drhold        (drhold),
        .cfg_lower     (cfg_lower),
        .cfg_upper     (cfg_upper),
        .cfg_step_up   (cfg_step_up),
        .cfg_step_down (cfg_step_down),
        .cfg_rate_up   (cfg_rate_up),
        .cfg_rate_down (cfg_rate_down),
        .drover        (drover),
        .ramp_out      (ramp_out),
        .ramp_active   (ramp_active)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Raw input history: [0] = value taken at the previous edge, [1] two edges ago, ...
    bit io_h[3];
    bit dc_h[3];
    bit dh_h[3];

    // Ramp model: parked means resting on the limit on the m_dir side.
    bit m_active, m_parked, m_dir;
    int m_acc, m_lo, m_hi, m_su, m_sd, m_ru, m_rd, m_phase;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit s_io, p_io, s_dc, s_dh;
        int nxt;
        s_io = io_h[1];
        p_io = io_h[2];
        s_dc = dc_h[1];
        s_dh = dh_h[1];
        if (sys_rst) begin
            m_active = 0; m_parked = 0; m_dir = 0;
            m_acc = 0; m_lo = 0; m_hi = 0; m_su = 0; m_sd = 0; m_ru = 0; m_rd = 0;
            m_phase = 0;
            for (int i = 0; i < 3; i++) begin
                io_h[i] = 0; dc_h[i] = 0; dh_h[i] = 0;
            end
            return;
        end
        if (s_io && !p_io) begin
            m_lo = int'(cfg_lower);
            m_hi = (int'(cfg_lower) > int'(cfg_upper)) ? int'(cfg_lower) : int'(cfg_upper);
            m_su = int'(cfg_step_up);
            m_sd = int'(cfg_step_down);
            m_ru = int'(cfg_rate_up);
            m_rd = int'(cfg_rate_down);
            m_acc = m_lo;
            m_phase = 0;
            m_active = 1;
            m_parked = 1;
            m_dir = s_dc && (m_lo == m_hi);
        end else if (m_active && !s_dh) begin
            if (s_dc != m_dir) begin
                m_dir = s_dc;
                m_phase = 0;
                m_parked = m_parked && (m_acc == (s_dc ? m_hi : m_lo));
            end else if (!m_parked) begin
                if (m_phase == (m_dir ? m_ru : m_rd)) begin
                    m_phase = 0;
                    if (m_dir) begin
                        nxt = m_acc + m_su;
                        if (nxt >= m_hi) begin m_acc = m_hi; m_parked = 1; end
                        else m_acc = nxt;
                    end else begin
                        nxt = m_acc - m_sd;
                        if (nxt <= m_lo) begin m_acc = m_lo; m_parked = 1; end
                        else m_acc = nxt;
                    end
                end else begin
                    m_phase++;
                end
            end
        end
        io_h[2] = io_h[1]; io_h[1] = io_h[0]; io_h[0] = io_update;
        dc_h[2] = dc_h[1]; dc_h[1] = dc_h[0]; dc_h[0] = drctl;
        dh_h[2] = dh_h[1]; dh_h[1] = dh_h[0]; dh_h[0] = drhold;
    endtask

    // Advance one clock; inputs are stable from the previous negedge.
    task automatic tick();
        model_edge();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        check_eq("ramp_out", int'(ramp_out), m_acc);
        check_eq("drover", int'(drover), int'(m_parked));
        check_eq("ramp_active", int'(ramp_active), int'(m_active));
    endtask

    task automatic set_cfg(input int lo, hi, su, sd, ru, rd);
        cfg_lower = 16'(lo); cfg_upper = 16'(hi);
        cfg_step_up = 16'(su); cfg_step_down = 16'(sd);
        cfg_rate_up = 16'(ru); cfg_rate_down = 16'(rd);
    endtask

    task automatic load_cfg(input int lo, hi, su, sd, ru, rd);
        set_cfg(lo, hi, su, sd, ru, rd);
        io_update = 1'b1;
        repeat (3) tick();
        io_update = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_drover(input bit level, input int budget, output int n);
        n = 0;
        while (drover !== level && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ramp_change(input int budget, output int n);
        logic [15:0] start;
        start = ramp_out;
        n = 0;
        while (ramp_out === start && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, t_fall;
        sys_rst = 1'b1; io_update = 1'b0; drctl = 1'b0; drhold = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check_eq("rst_ramp_out", int'(ramp_out), 0);
        check_eq("rst_drover", int'(drover), 0);
        check_eq("rst_active", int'(ramp_active), 0);
        sys_rst = 1'b0;

        // 1: control activity without a load leaves the block idle.
        for (int i = 0; i < 20; i++) begin
            drctl = 1'($urandom_range(1));
            drhold = 1'($urandom_range(1));
            tick();
        end
        check_eq("t1_active", int'(ramp_active), 0);
        check_eq("t1_ramp", int'(ramp_out), 0);
        drctl = 1'b0; drhold = 1'b0;
        repeat (3) tick();

        // 2: ramp up 100 -> 200 in steps of 10 every 5 clocks.
        load_cfg(100, 200, 10, 30, 4, 0);
        check_eq("t2_load_ramp", int'(ramp_out), 100);
        check_eq("t2_load_drover", int'(drover), 1);
        drctl = 1'b1;
        repeat (2) tick();
        check_eq("t2_before_fall", int'(drover), 1);
        tick();
        check_eq("t2_fall", int'(drover), 0);
        wait_drover(1'b1, 200, n);
        check_eq("t2_up_clocks", n, 50);
        check_eq("t2_top_value", int'(ramp_out), 200);

        // 3: ramp down by 30 every clock, saturating at 100.
        drctl = 1'b0;
        repeat (3) tick();
        check_eq("t3_down_start", int'(ramp_out), 200);
        tick(); check_eq("t3_step1", int'(ramp_out), 170);
        tick(); check_eq("t3_step2", int'(ramp_out), 140);
        tick(); check_eq("t3_step3", int'(ramp_out), 110);
        check_eq("t3_not_yet", int'(drover), 0);
        tick(); check_eq("t3_step4", int'(ramp_out), 100);
        check_eq("t3_drover", int'(drover), 1);

        // 4: hold for 20 clocks at 150 stretches the up-time by exactly 20.
        drctl = 1'b1;
        repeat (3) tick();
        t_fall = cyc;
        n = 0;
        while (ramp_out != 16'd150 && n < 100) begin tick(); n++; end
        check_eq("t4_reach_150", int'(ramp_out), 150);
        drhold = 1'b1;
        repeat (20) tick();
        drhold = 1'b0;
        check_eq("t4_held", int'(ramp_out), 150);
        wait_drover(1'b1, 200, n);
        check_eq("t4_up_clocks", cyc - t_fall, 70);
        check_eq("t4_top_value", int'(ramp_out), 200);

        // 5: reload mid-DOWN onto the full range; big up-steps must saturate, not wrap.
        drctl = 1'b0;
        repeat (4) tick();
        set_cfg(0, 16'hFFFF, 16'hFFF0, 30, 1, 0);
        io_update = 1'b1;
        repeat (2) tick();
        check_eq("t5_mid_down", int'(drover), 0);
        tick();
        io_update = 1'b0;
        check_eq("t5_reload", int'(ramp_out), 0);
        drctl = 1'b1;
        wait_ramp_change(20, n);
        check_eq("t5_step1", int'(ramp_out), 16'hFFF0);
        wait_ramp_change(20, n);
        check_eq("t5_step2", int'(ramp_out), 16'hFFFF);
        check_eq("t5_drover", int'(drover), 1);

        // 6: inverted window pins the ramp on the lower limit; then reset mid-ramp.
        drctl = 1'b0;
        repeat (3) tick();
        load_cfg(300, 200, 5, 5, 0, 0);
        check_eq("t6_pin_dn", int'(ramp_out), 300);
        check_eq("t6_drover_dn", int'(drover), 1);
        drctl = 1'b1;
        repeat (6) tick();
        check_eq("t6_pin_up", int'(ramp_out), 300);
        check_eq("t6_drover_up", int'(drover), 1);
        load_cfg(0, 1000, 5, 5, 0, 0);
        repeat (10) tick();
        check_eq("t6_ramping", int'(drover), 0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_eq("t6_rst_ramp", int'(ramp_out), 0);
        check_eq("t6_rst_drover", int'(drover), 0);
        check_eq("t6_rst_active", int'(ramp_active), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) io_update = ~io_update;
            if ($urandom_range(15) == 0) drctl = ~drctl;
            if ($urandom_range(31) == 0) drhold = ~drhold;
            if ($urandom_range(15) == 0) begin
                set_cfg(int'($urandom_range(65535)), int'($urandom_range(65535)),
                        ($urandom_range(7) == 0) ? 0 : int'($urandom_range(16383)),
                        ($urandom_range(7) == 0) ? 0 : int'($urandom_range(16383)),
                        int'($urandom_range(3)), int'($urandom_range(3)));
            end
            sys_rst = ($urandom_range(999) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
